// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN sliding-window generator.
package cnn_pkg;

    localparam int unsigned DATA_WIDTH_DEF      = 32;
    localparam int unsigned KERNEL_ROW_SIZE_DEF = 3;

    typedef logic [DATA_WIDTH_DEF-1:0] pixel_t;
    typedef pixel_t [KERNEL_ROW_SIZE_DEF-1:0] column_t;

    typedef enum logic [2:0] {
        StIdle,
        StRowFill,
        StStream,
        StRowEnd,
        StDrain,
        StDone
    } win_state_t;

endpackage

// File: rtl/cnn_col_fifo.sv
// Small synchronous FIFO holding one K-lane pixel column per entry.
module cnn_col_fifo #(
    parameter int unsigned WIDTH       = 96,
    parameter int unsigned DEPTH       = 3,
    parameter int unsigned COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   wr_en;
    logic                   rd_en;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == COUNT_WIDTH'(DEPTH));
    assign o_count = count_q;
    assign o_rdata = mem_q[rd_ptr_q];

    // Guarded so a misbehaving producer cannot corrupt the pointers.
    assign wr_en = i_push && (!o_full || i_pop);
    assign rd_en = i_pop && !o_empty;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= i_wdata;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (rd_en) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            count_q <= count_q + COUNT_WIDTH'(wr_en) - COUNT_WIDTH'(rd_en);
        end
    end

endmodule

// File: rtl/cnn_window_gen.sv
// Reads the CNN input memory column by column and builds a sliding KxK window
// with valid/ready backpressure; read issue is credit-limited so the FIFO never overflows.
module cnn_window_gen
    import cnn_pkg::*;
#(
    parameter int unsigned IMG_WIDTH         = 224,
    parameter int unsigned IMG_HEIGHT        = 224,
    parameter int unsigned KERNEL_ROW_SIZE   = KERNEL_ROW_SIZE_DEF,
    parameter int unsigned DATA_WIDTH        = DATA_WIDTH_DEF,
    parameter int unsigned BRAM_READ_LATENCY = 2,
    parameter int unsigned ADDRESS_WIDTH     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                                                   i_clock,
    input  logic                                                   i_reset,
    input  logic                                                   i_start,
    input  logic                                                   i_mem_busy,
    output logic                                                   o_renable,
    output logic [ADDRESS_WIDTH-1:0]                               o_raddress,
    input  logic [KERNEL_ROW_SIZE-1:0][DATA_WIDTH-1:0]             i_bram_data,
    output logic [KERNEL_ROW_SIZE-1:0][KERNEL_ROW_SIZE-1:0][DATA_WIDTH-1:0] o_window,
    output logic                                                   o_valid,
    input  logic                                                   i_ready,
    output logic [15:0]                                            o_row,
    output logic [15:0]                                            o_col,
    output logic                                                   o_busy,
    output logic                                                   o_done
);

    localparam int unsigned K          = KERNEL_ROW_SIZE;
    localparam int unsigned LAT        = BRAM_READ_LATENCY;
    localparam int unsigned FIFO_DEPTH = LAT + 1;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef logic [K-1:0][DATA_WIDTH-1:0] lanes_t;
    typedef logic [K-1:0][K-1:0][DATA_WIDTH-1:0] window_t;

    win_state_t             state_q, state_d;
    logic [15:0]            row_q, row_d;
    logic [15:0]            rd_col_q, rd_col_d;
    logic [15:0]            pop_cnt_q, pop_cnt_d;
    logic [ADDRESS_WIDTH-1:0] raddr_q, raddr_d;
    logic [LAT-1:0]         inflight_q, inflight_d;
    window_t                win_q, win_d;
    logic                   valid_q, valid_d;
    logic [15:0]            out_row_q, out_row_d;
    logic [15:0]            out_col_q, out_col_d;

    lanes_t                 fifo_rdata;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   fifo_pop;
    logic                   active;
    logic                   issue;
    int unsigned            occupancy;
    logic                   unused_fifo_full;

    assign unused_fifo_full = fifo_full;

    cnn_col_fifo #(
        .WIDTH       (K * DATA_WIDTH),
        .DEPTH       (FIFO_DEPTH),
        .COUNT_WIDTH (CNT_W)
    ) u_col_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (inflight_q[LAT-1]),
        .i_wdata (i_bram_data),
        .i_pop   (fifo_pop),
        .o_rdata (fifo_rdata),
        .o_count (fifo_count),
        .o_empty (fifo_empty),
        .o_full  (fifo_full)
    );

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        rd_col_d  = rd_col_q;
        pop_cnt_d = pop_cnt_q;
        raddr_d   = raddr_q;
        win_d     = win_q;
        valid_d   = valid_q;
        out_row_d = out_row_q;
        out_col_d = out_col_q;

        active   = (state_q == StRowFill) || (state_q == StStream);
        fifo_pop = active && !fifo_empty && (!valid_q || i_ready);

        // Slots held by buffered or returning columns; a pop this cycle frees one.
        occupancy = 32'(fifo_count);
        for (int i = 0; i < LAT; i++) begin
            occupancy = occupancy + 32'(inflight_q[i]);
        end
        issue = active && (rd_col_q < 16'(IMG_WIDTH))
                && (occupancy < FIFO_DEPTH + 32'(fifo_pop));

        inflight_d[0] = issue;
        for (int i = 1; i < LAT; i++) begin
            inflight_d[i] = inflight_q[i-1];
        end

        if (issue) begin
            rd_col_d = rd_col_q + 16'd1;
            raddr_d  = raddr_q + ADDRESS_WIDTH'(1);
        end

        if (fifo_pop) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][K-1] = fifo_rdata[r];
            end
            pop_cnt_d = pop_cnt_q + 16'd1;
            if (pop_cnt_q + 16'd1 >= 16'(K)) begin
                valid_d   = 1'b1;
                out_row_d = row_q;
                out_col_d = pop_cnt_q + 16'd1 - 16'(K);
            end else begin
                valid_d = 1'b0;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (i_start && !i_mem_busy) begin
                    state_d   = StRowFill;
                    row_d     = '0;
                    rd_col_d  = '0;
                    pop_cnt_d = '0;
                    raddr_d   = '0;
                end
            end
            StRowFill: begin
                if (fifo_pop && (pop_cnt_q == 16'(K - 2))) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if (fifo_pop && (pop_cnt_q == 16'(IMG_WIDTH - 1))) begin
                    state_d = StRowEnd;
                end
            end
            StRowEnd: begin
                rd_col_d  = '0;
                pop_cnt_d = '0;
                if (row_q == 16'(IMG_HEIGHT - K)) begin
                    state_d = StDrain;
                end else begin
                    row_d   = row_q + 16'd1;
                    state_d = StRowFill;
                end
            end
            StDrain: begin
                if (!valid_q || i_ready) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= StIdle;
            row_q      <= '0;
            rd_col_q   <= '0;
            pop_cnt_q  <= '0;
            raddr_q    <= '0;
            inflight_q <= '0;
            win_q      <= '0;
            valid_q    <= 1'b0;
            out_row_q  <= '0;
            out_col_q  <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            rd_col_q   <= rd_col_d;
            pop_cnt_q  <= pop_cnt_d;
            raddr_q    <= raddr_d;
            inflight_q <= inflight_d;
            win_q      <= win_d;
            valid_q    <= valid_d;
            out_row_q  <= out_row_d;
            out_col_q  <= out_col_d;
        end
    end

    assign o_renable  = issue;
    assign o_raddress = raddr_q;
    assign o_window   = win_q;
    assign o_valid    = valid_q;
    assign o_row      = out_row_q;
    assign o_col      = out_col_q;
    assign o_busy     = (state_q != StIdle) && (state_q != StDone);
    assign o_done     = (state_q == StDone);

endmodule

// File: tb/tb_cnn_window_gen.sv
// Scoreboard bench: three DUT configurations, each fed by a latency-accurate BRAM model.
module tb_cnn_window_gen;

    typedef struct {
        int                     cfg;
        int                     row;
        int                     col;
        logic [2:0][2:0][31:0]  win;
    } exp_t;

    logic clk;
    logic rst     [3];
    logic start   [3];
    logic mbusy   [3];
    logic ready   [3];
    logic ren     [3];
    logic valid_s [3];
    logic busy_s  [3];
    logic done_s  [3];
    logic [15:0] row_s [3];
    logic [15:0] col_s [3];
    logic [2:0][2:0][31:0] win_s [3];

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   n_win    [3] = '{0, 0, 0};
    int   last_row [3] = '{0, 0, 0};
    int   last_col [3] = '{0, 0, 0};
    int   done_cnt [3] = '{0, 0, 0};
    bit   held_v   [3] = '{0, 0, 0};
    logic [2:0][2:0][31:0] held_win [3];
    logic [15:0] held_row [3];
    logic [15:0] held_col [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int unsigned W   = (g == 0) ? 4 : 6;
        localparam int unsigned H   = (g == 0) ? 4 : 5;
        localparam int unsigned L   = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
        localparam int unsigned ADW = $clog2(W * H);

        logic [ADW-1:0]   raddr;
        logic [2:0][31:0] bd;
        bit               v_pipe [L];
        int unsigned      a_pipe [L];
        int               ren_cnt = 0;

        cnn_window_gen #(
            .IMG_WIDTH         (W),
            .IMG_HEIGHT        (H),
            .KERNEL_ROW_SIZE   (3),
            .DATA_WIDTH        (32),
            .BRAM_READ_LATENCY (L)
        ) u_dut (
            .i_clock     (clk),
            .i_reset     (rst[g]),
            .i_start     (start[g]),
            .i_mem_busy  (mbusy[g]),
            .o_renable   (ren[g]),
            .o_raddress  (raddr),
            .i_bram_data (bd),
            .o_window    (win_s[g]),
            .o_valid     (valid_s[g]),
            .i_ready     (ready[g]),
            .o_row       (row_s[g]),
            .o_col       (col_s[g]),
            .o_busy      (busy_s[g]),
            .o_done      (done_s[g])
        );

        // BRAM: lane k at address a holds pixel a + k*W; poison when no read matures.
        always @(posedge clk) begin
            v_pipe[0] <= ren[g];
            a_pipe[0] <= 32'(raddr);
            for (int i = 1; i < L; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                a_pipe[i] <= a_pipe[i-1];
            end
            if (ren[g]) ren_cnt <= ren_cnt + 1;
        end

        always_comb begin
            for (int k = 0; k < 3; k++) begin
                bd[k] = v_pipe[L-1] ? 32'(a_pipe[L-1] + 32'(k) * W) : 32'hdead_0000;
            end
        end
    end

    function automatic void chk(input bit ok, input string name, input string act,
                                input string req);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %s, expected %s", name, act, req);
        end
    endfunction

    // Monitor: pops the scoreboard on every handshake, checks stall stability and done.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rst[g]) begin
                held_v[g] = 1'b0;
            end else begin
                if (held_v[g]) begin
                    chk(valid_s[g] && win_s[g] == held_win[g] && row_s[g] == held_row[g]
                        && col_s[g] == held_col[g], "stall_stable",
                        $sformatf("v=%0b r=%0d c=%0d w=%h", valid_s[g], row_s[g], col_s[g],
                                  win_s[g]),
                        $sformatf("v=1 r=%0d c=%0d w=%h", held_row[g], held_col[g],
                                  held_win[g]));
                end
                if (valid_s[g] && ready[g]) begin
                    chk(sb_q.size() != 0 && sb_q[0].cfg == g, "window_expected",
                        $sformatf("cfg%0d window r=%0d c=%0d", g, row_s[g], col_s[g]),
                        "a queued window for this cfg");
                    if (sb_q.size() != 0 && sb_q[0].cfg == g) begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk(int'(row_s[g]) == e.row, "win_row",
                            $sformatf("%0d", row_s[g]), $sformatf("%0d", e.row));
                        chk(int'(col_s[g]) == e.col, "win_col",
                            $sformatf("%0d", col_s[g]), $sformatf("%0d", e.col));
                        chk(win_s[g] == e.win, "win_data",
                            $sformatf("%h", win_s[g]), $sformatf("%h", e.win));
                    end
                    n_win[g]++;
                    last_row[g] = int'(row_s[g]);
                    last_col[g] = int'(col_s[g]);
                end
                held_v[g]   = valid_s[g] && !ready[g];
                held_win[g] = win_s[g];
                held_row[g] = row_s[g];
                held_col[g] = col_s[g];
                if (done_s[g]) begin
                    int pend;
                    pend = 0;
                    foreach (sb_q[i]) if (sb_q[i].cfg == g) pend++;
                    chk(pend == 0, "done_no_pending", $sformatf("%0d pending", pend),
                        "0 pending");
                    done_cnt[g]++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_pass(input int g, input int w, input int h);
        exp_t e;
        for (int row = 0; row <= h - 3; row++) begin
            for (int col = 0; col <= w - 3; col++) begin
                e.cfg = g;
                e.row = row;
                e.col = col;
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        e.win[r][c] = 32'((row + r) * w + col + c);
                    end
                end
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_start(input int g);
        start[g] = 1'b1;
        tick(1);
        start[g] = 1'b0;
    endtask

    task automatic wait_valid(input int g, input int budget, output int n);
        n = 0;
        while (!valid_s[g] && n < budget) begin
            tick(1);
            n++;
        end
        chk(valid_s[g] == 1'b1, "wait_valid", $sformatf("no valid after %0d", n),
            "o_valid within budget");
    endtask

    task automatic wait_done(input int g, input int budget, input bit toggle);
        int n;
        n = 0;
        while (!done_s[g] && n < budget) begin
            if (toggle) ready[g] = ~ready[g];
            tick(1);
            n++;
        end
        chk(done_s[g] == 1'b1, "wait_done", $sformatf("no done after %0d", n),
            "o_done within budget");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w0;
        int d0;
        int base;
        logic [2:0][31:0] e_row;

        for (int g = 0; g < 3; g++) begin
            rst[g] = 1'b1;
            start[g] = 1'b0;
            mbusy[g] = 1'b0;
            ready[g] = 1'b1;
        end
        tick(4);
        for (int g = 0; g < 3; g++) rst[g] = 1'b0;
        tick(1);

        chk(valid_s[0] == 1'b0, "rst_valid", $sformatf("%0b", valid_s[0]), "0");
        chk(busy_s[0] == 1'b0, "rst_busy", $sformatf("%0b", busy_s[0]), "0");
        chk(done_s[0] == 1'b0, "rst_done", $sformatf("%0b", done_s[0]), "0");
        chk(ren[0] == 1'b0, "rst_renable", $sformatf("%0b", ren[0]), "0");
        chk(row_s[0] == 16'd0, "rst_row", $sformatf("%0d", row_s[0]), "0");
        chk(col_s[0] == 16'd0, "rst_col", $sformatf("%0d", col_s[0]), "0");
        chk(win_s[0] == '0, "rst_window", $sformatf("%h", win_s[0]), "0");

        // Start is held off while the memory is busy.
        mbusy[0] = 1'b1;
        base = g_cfg[0].ren_cnt;
        pulse_start(0);
        tick(5);
        chk(busy_s[0] == 1'b0, "membusy_idle", $sformatf("busy=%0b", busy_s[0]), "busy=0");
        chk(g_cfg[0].ren_cnt == base, "membusy_noread",
            $sformatf("%0d reads", g_cfg[0].ren_cnt - base), "0 reads");
        mbusy[0] = 1'b0;

        // 4x4, always ready, plus a start pulse mid-pass that must be ignored.
        w0 = n_win[0];
        d0 = done_cnt[0];
        push_pass(0, 4, 4);
        pulse_start(0);
        wait_valid(0, 100, n);
        chk(n >= 5, "first_latency", $sformatf("%0d cycles", n), ">= 5 cycles");
        e_row[0] = 32'd0; e_row[1] = 32'd1; e_row[2] = 32'd2;
        chk(win_s[0][0] == e_row, "first_win_r0", $sformatf("%h", win_s[0][0]),
            $sformatf("%h", e_row));
        e_row[0] = 32'd4; e_row[1] = 32'd5; e_row[2] = 32'd6;
        chk(win_s[0][1] == e_row, "first_win_r1", $sformatf("%h", win_s[0][1]),
            $sformatf("%h", e_row));
        e_row[0] = 32'd8; e_row[1] = 32'd9; e_row[2] = 32'd10;
        chk(win_s[0][2] == e_row, "first_win_r2", $sformatf("%h", win_s[0][2]),
            $sformatf("%h", e_row));
        pulse_start(0);
        chk(busy_s[0] == 1'b1, "busy_in_pass", $sformatf("%0b", busy_s[0]), "1");
        wait_done(0, 200, 1'b0);
        chk(n_win[0] - w0 == 4, "pass1_count", $sformatf("%0d", n_win[0] - w0), "4");
        tick(10);
        chk(busy_s[0] == 1'b0 && valid_s[0] == 1'b0, "no_restart",
            $sformatf("busy=%0b valid=%0b", busy_s[0], valid_s[0]), "busy=0 valid=0");
        chk(done_cnt[0] - d0 == 1, "single_done", $sformatf("%0d", done_cnt[0] - d0), "1");

        // Same image with i_ready toggling every cycle.
        w0 = n_win[0];
        push_pass(0, 4, 4);
        pulse_start(0);
        wait_done(0, 300, 1'b1);
        ready[0] = 1'b1;
        chk(n_win[0] - w0 == 4, "toggle_count", $sformatf("%0d", n_win[0] - w0), "4");

        // 6x5 latency 1: stall from the first window; reads stop at 3 pops + 2 buffered.
        ready[1] = 1'b0;
        base = g_cfg[1].ren_cnt;
        push_pass(1, 6, 5);
        pulse_start(1);
        wait_valid(1, 100, n);
        tick(20);
        chk(g_cfg[1].ren_cnt - base == 5, "stall_reads",
            $sformatf("%0d reads", g_cfg[1].ren_cnt - base), "5 reads");
        chk(ren[1] == 1'b0, "stall_renable_low", $sformatf("%0b", ren[1]), "0");
        ready[1] = 1'b1;
        wait_done(1, 400, 1'b0);
        chk(n_win[1] == 12, "lat1_count", $sformatf("%0d", n_win[1]), "12");
        chk(last_row[1] == 2 && last_col[1] == 3, "lat1_last",
            $sformatf("r=%0d c=%0d", last_row[1], last_col[1]), "r=2 c=3");

        // 6x5 latency 3, always ready.
        push_pass(2, 6, 5);
        pulse_start(2);
        wait_done(2, 400, 1'b0);
        chk(n_win[2] == 12, "lat3_count", $sformatf("%0d", n_win[2]), "12");
        chk(last_row[2] == 2 && last_col[2] == 3, "lat3_last",
            $sformatf("r=%0d c=%0d", last_row[2], last_col[2]), "r=2 c=3");

        // Reset mid-stream aborts the pass without a done pulse.
        push_pass(0, 4, 4);
        pulse_start(0);
        wait_valid(0, 100, n);
        tick(1);
        rst[0] = 1'b1;
        tick(1);
        chk(!valid_s[0] && !busy_s[0] && !done_s[0] && !ren[0] && row_s[0] == 16'd0
            && col_s[0] == 16'd0 && win_s[0] == '0, "midreset_zero",
            $sformatf("v=%0b b=%0b d=%0b re=%0b r=%0d c=%0d", valid_s[0], busy_s[0],
                      done_s[0], ren[0], row_s[0], col_s[0]), "all outputs 0");
        rst[0] = 1'b0;
        sb_q.delete();
        d0 = done_cnt[0];
        tick(10);
        chk(done_cnt[0] == d0 && busy_s[0] == 1'b0, "midreset_nodone",
            $sformatf("done+%0d busy=%0b", done_cnt[0] - d0, busy_s[0]), "done+0 busy=0");
        w0 = n_win[0];
        push_pass(0, 4, 4);
        pulse_start(0);
        wait_valid(0, 100, n);
        chk(row_s[0] == 16'd0 && col_s[0] == 16'd0, "restart_origin",
            $sformatf("r=%0d c=%0d", row_s[0], col_s[0]), "r=0 c=0");
        wait_done(0, 200, 1'b0);
        chk(n_win[0] - w0 == 4, "restart_count", $sformatf("%0d", n_win[0] - w0), "4");
        tick(3);
        chk(sb_q.size() == 0, "queue_empty", $sformatf("%0d left", sb_q.size()), "0 left");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
